// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester round-robin arbiter for the 16x8 lab RAM
// Adds tagged read returns and a clear sweep that zeroes bits [1:0] of every word.
module ram_port_arbiter #(
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int WW     = 2,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          wr0,
    input  logic [AW-1:0] addr0,
    input  logic [WW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          wr1,
    input  logic [AW-1:0] addr1,
    input  logic [WW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_inaddr,
    output logic [AW-1:0] ram_outaddr,
    output logic [WW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    localparam int DEPTH = 2 ** AW;
    localparam int NSTG  = RD_LAT + 1;

    typedef enum logic {RUN, CLEAR} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic          prio, prio_nx;
    logic          grant0, grant1;
    logic          clr_we;
    logic          grant_wr, grant_rd;
    logic [AW-1:0] sel_addr;
    logic [WW-1:0] sel_wdata;

    // tag_* travels with ram_outaddr; pipe_* covers the RAM's read latency
    logic            tag_v, tag_id;
    logic [NSTG-1:0] pipe_v, pipe_id;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        prio_nx   = prio;
        grant0    = 1'b0;
        grant1    = 1'b0;
        clr_we    = 1'b0;
        case (state)
            RUN: begin
                if (clr_start) begin
                    // cnt idles at 0, so the entry edge already issues address 0
                    state_nx = CLEAR;
                    clr_we   = 1'b1;
                    cnt_nx   = cnt + 1'b1;
                end else begin
                    grant0 = req0 && (!req1 || !prio);
                    grant1 = req1 && (!req0 || prio);
                    if (grant0) prio_nx = 1'b1;
                    if (grant1) prio_nx = 1'b0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                cnt_nx = cnt + 1'b1;
                if (cnt == AW'(DEPTH - 1)) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
        sel_addr  = grant1 ? addr1 : addr0;
        sel_wdata = grant1 ? wdata1 : wdata0;
        grant_wr  = (grant0 && wr0) || (grant1 && wr1);
        grant_rd  = (grant0 && !wr0) || (grant1 && !wr1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            cnt         <= '0;
            prio        <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            clr_busy    <= 1'b0;
            ram_we      <= 1'b0;
            ram_inaddr  <= '0;
            ram_outaddr <= '0;
            ram_din     <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            prio     <= prio_nx;
            gnt0     <= grant0;
            gnt1     <= grant1;
            clr_busy <= clr_we;
            ram_we   <= clr_we || grant_wr;
            if (clr_we) begin
                ram_inaddr <= cnt;
                ram_din    <= '0;
            end else if (grant_wr) begin
                ram_inaddr <= sel_addr;
                ram_din    <= sel_wdata;
            end
            if (grant_rd) ram_outaddr <= sel_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v   <= 1'b0;
            tag_id  <= 1'b0;
            pipe_v  <= '0;
            pipe_id <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
        end else begin
            tag_v   <= grant_rd;
            tag_id  <= grant1;
            pipe_v  <= {pipe_v[NSTG-2:0], tag_v};
            pipe_id <= {pipe_id[NSTG-2:0], tag_id};
            rvalid0 <= pipe_v[NSTG-1] && !pipe_id[NSTG-1];
            rvalid1 <= pipe_v[NSTG-1] && pipe_id[NSTG-1];
            if (pipe_v[NSTG-1]) rdata <= ram_dout;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
// Reference model: per-requester command queues, a word array and a last-granted pointer.
module tb_ram_port_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [1:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, clr_busy, ram_we;
    logic [7:0] rdata;
    logic       clr_start = 1'b0;
    logic [3:0] ram_inaddr, ram_outaddr;
    logic [1:0] ram_din;
    logic [7:0] ram_dout = '0;

    typedef struct packed {logic wr; logic [3:0] addr; logic [1:0] wdata;} cmd_t;
    typedef struct {logic id; logic [7:0] data; int due;} exp_t;

    cmd_t       q0[$], q1[$];
    exp_t       sb[$];
    exp_t       m_e;
    logic [7:0] init_mem[16];
    logic [7:0] ram_mem[16];
    logic [7:0] ref_mem[16];
    logic       ram_loaded = 1'b0;
    logic [3:0] ra = '0;
    logic [7:0] rs = '0;
    int         edge_n = 0;
    int         checks = 0;
    int         errors = 0;
    int         prio = 0;
    int         left = 0;

    ram_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .clr_start(clr_start), .clr_busy(clr_busy),
        .ram_we(ram_we), .ram_inaddr(ram_inaddr), .ram_outaddr(ram_outaddr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Lab RAM: sub-word write, address captured one edge, data out two edges later
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= init_mem[i];
            ram_loaded <= 1'b1;
        end else if (ram_we) begin
            ram_mem[ram_inaddr][1:0] <= ram_din;
        end
        ra       <= ram_outaddr;
        rs       <= ram_mem[ra];
        ram_dout <= rs;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic cmd_t mk(input logic wr, input int addr, input int wd);
        cmd_t c;
        c.wr    = wr;
        c.addr  = 4'(addr);
        c.wdata = 2'(wd);
        return c;
    endfunction

    task automatic drive();
        req0 = (q0.size() > 0);
        req1 = (q1.size() > 0);
        if (req0) begin wr0 = q0[0].wr; addr0 = q0[0].addr; wdata0 = q0[0].wdata; end
        if (req1) begin wr1 = q1[0].wr; addr1 = q1[0].addr; wdata1 = q1[0].wdata; end
        clr_start = 1'b0;
    endtask

    task automatic step();
        int   g;
        logic e0, e1, eb;
        cmd_t c;
        @(posedge clk);
        #1;
        e0 = 1'b0; e1 = 1'b0; eb = 1'b0;
        if (left > 0) begin
            left--;
            eb = 1'b1;
        end else if (clr_start) begin
            left = 15;
            eb   = 1'b1;
            for (int i = 0; i < 16; i++) ref_mem[i][1:0] = 2'b00;
        end else if (req0 || req1) begin
            g    = (req0 && req1) ? prio : (req1 ? 1 : 0);
            prio = 1 - g;
            if (g == 0) begin e0 = 1'b1; c = q0.pop_front(); end
            else        begin e1 = 1'b1; c = q1.pop_front(); end
            if (c.wr) ref_mem[c.addr][1:0] = c.wdata;
            else sb.push_back('{id: g[0], data: ref_mem[c.addr], due: edge_n + 4});
        end
        chk("gnt0", 32'(gnt0), 32'(e0));
        chk("gnt1", 32'(gnt1), 32'(e1));
        chk("clr_busy", 32'(clr_busy), 32'(eb));
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("reset_outputs",
            32'({gnt0, gnt1, rvalid0, rvalid1, clr_busy, ram_we, ram_inaddr, ram_outaddr, ram_din, rdata}), 32'd0);
        q0.delete();
        q1.delete();
        sb.delete();
        prio = 0;
        left = 0;
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || left > 0); i++) step();
        chk("drain_pending", 32'(q0.size() + q1.size() + sb.size()), 32'd0);
    endtask

    // Read-return monitor, decoupled from the stimulus flow
    always @(posedge clk) begin
        #1;
        if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 32'({rvalid1, rvalid0}), 32'd0);
            end else begin
                m_e = sb.pop_front();
                chk("rvalid_id", 32'({rvalid1, rvalid0}), m_e.id ? 32'd2 : 32'd1);
                chk("rdata", 32'(rdata), 32'(m_e.data));
                chk("return_edge", edge_n, m_e.due);
            end
        end else if (sb.size() > 0 && edge_n > sb[0].due) begin
            chk("return_missing", edge_n, sb[0].due);
            void'(sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            init_mem[i] = 8'($urandom);
            ref_mem[i]  = init_mem[i];
        end
        #2;
        do_reset();

        // write then read the same address from requester 0
        q0.push_back(mk(1'b1, 3, 2));
        q0.push_back(mk(1'b0, 3, 0));
        drive();
        drain();

        // both requesters hold reads: grants alternate
        q0.push_back(mk(1'b0, 1, 0));
        q0.push_back(mk(1'b0, 1, 0));
        q1.push_back(mk(1'b0, 2, 0));
        q1.push_back(mk(1'b0, 2, 0));
        drive();
        drain();

        // back-to-back reads with an interleaved write
        q1.push_back(mk(1'b0, 4, 0));
        q1.push_back(mk(1'b0, 5, 0));
        q1.push_back(mk(1'b0, 6, 0));
        q0.push_back(mk(1'b1, 5, 1));
        drive();
        drain();

        // clear sweep while requester 0 waits, then read every address
        for (int i = 0; i < 16; i++) q0.push_back(mk(1'b0, i, 0));
        drive();
        clr_start = 1'b1;
        drain();

        // clear start and requester 1 on the same edge
        q1.push_back(mk(1'b0, 7, 0));
        drive();
        clr_start = 1'b1;
        drain();

        // reset with a read in flight; pointer returns to requester 0
        q0.push_back(mk(1'b0, 9, 0));
        drive();
        step();
        do_reset();
        repeat (6) step();
        q0.push_back(mk(1'b0, 10, 0));
        q1.push_back(mk(1'b0, 11, 0));
        drive();
        drain();

        // randomized traffic with occasional clear sweeps
        repeat (500) begin
            if (q0.size() < 3 && $urandom_range(0, 2) == 0)
                q0.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3)));
            if (q1.size() < 3 && $urandom_range(0, 2) == 0)
                q1.push_back(mk(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 3)));
            drive();
            if ($urandom_range(0, 59) == 0) clr_start = 1'b1;
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
